// File: rtl/hex_mem_arb.sv
// hex_mem_arb: shares the single-port hex processor memory between three requesters.
//
// Requesters, highest priority first:
//   host  - loader/debug port, read/write, always wins
//   data  - core load/store port, read/write
//   fetch - core instruction fetch, read-only, byte addressed
// Data normally beats fetch. After FETCH_MAX_WAIT consecutive denied fetch cycles,
// fetch beats data. Grants are combinational, so a winning request is accepted in
// its first cycle. Read data returns one cycle later on the winner's rvalid.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   host_req/we/addr/wdata          host request (word address)
//   host_gnt/rvalid/rdata           host grant and read return
//   data_req/we/addr/wdata          core data request (word address)
//   data_gnt/rvalid/rdata           core data grant and read return
//   fetch_req/addr                  instruction fetch request (byte address)
//   fetch_gnt/rvalid/instr          fetch grant and returned instruction byte
//   mem_en/we/addr/wdata            synchronous memory request
//   mem_rdata                       memory read data, one cycle after a read

module hex_mem_arb #(
  parameter int unsigned FETCH_MAX_WAIT = 4  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,

  input  logic        data_req,
  input  logic        data_we,
  input  logic [15:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,

  input  logic        fetch_req,
  input  logic [17:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_rvalid,
  output logic [7:0]  fetch_instr,

  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] MaxWait = 4'(FETCH_MAX_WAIT);

  // Owner of the read whose data arrives on mem_rdata this cycle.
  typedef enum logic [1:0] {
    TagNone  = 2'd0,
    TagHost  = 2'd1,
    TagData  = 2'd2,
    TagFetch = 2'd3
  } tag_e;

  logic [3:0] wait_cnt_q, wait_cnt_d;
  tag_e       tag_q, tag_d;
  logic [1:0] bsel_q, bsel_d;
  logic       starved;

  assign starved = (wait_cnt_q == MaxWait);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    host_gnt  = 1'b0;
    data_gnt  = 1'b0;
    fetch_gnt = 1'b0;
    if (host_req) begin
      host_gnt = 1'b1;
    end else if (fetch_req && (starved || !data_req)) begin
      fetch_gnt = 1'b1;
    end else if (data_req) begin
      data_gnt = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory request mux; idle bus drives all zeros
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 32'h0000_0000;
    if (host_gnt) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (data_gnt) begin
      mem_en    = 1'b1;
      mem_we    = data_we;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (fetch_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = fetch_addr[17:2];
    end
  end

  // ---------------------------------------------------------------------------
  // Next state: read tag, fetch byte select, starvation counter
  // ---------------------------------------------------------------------------
  always_comb begin
    tag_d = TagNone;
    if (host_gnt) begin
      tag_d = host_we ? TagNone : TagHost;
    end else if (data_gnt) begin
      tag_d = data_we ? TagNone : TagData;
    end else if (fetch_gnt) begin
      tag_d = TagFetch;
    end
  end

  always_comb begin
    bsel_d = bsel_q;
    if (fetch_gnt) begin
      bsel_d = fetch_addr[1:0];
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!fetch_req || fetch_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != MaxWait) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= 4'd0;
      tag_q      <= TagNone;
      bsel_q     <= 2'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      tag_q      <= tag_d;
      bsel_q     <= bsel_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return
  // ---------------------------------------------------------------------------
  assign host_rvalid  = (tag_q == TagHost);
  assign data_rvalid  = (tag_q == TagData);
  assign fetch_rvalid = (tag_q == TagFetch);

  assign host_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  // Gated so the byte reads as zero when no fetch is returning, which keeps the
  // output defined out of reset regardless of what the memory presents.
  always_comb begin
    fetch_instr = 8'h00;
    if (fetch_rvalid) begin
      unique case (bsel_q)
        2'd0: fetch_instr = mem_rdata[7:0];
        2'd1: fetch_instr = mem_rdata[15:8];
        2'd2: fetch_instr = mem_rdata[23:16];
        2'd3: fetch_instr = mem_rdata[31:24];
        default: fetch_instr = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_mem_arb.sv
// Directed bench for hex_mem_arb: one table row per clock cycle, plus hand-written
// reset sequences. A behavioural synchronous memory sits on the mem_* port.

module tb_hex_mem_arb;

  logic        clk;
  logic        rst;
  logic        host_req, host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt, host_rvalid;
  logic [31:0] host_rdata;
  logic        data_req, data_we;
  logic [15:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;
  logic        fetch_req;
  logic [17:0] fetch_addr;
  logic        fetch_gnt, fetch_rvalid;
  logic [7:0]  fetch_instr;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  hex_mem_arb #(.FETCH_MAX_WAIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_gnt     (host_gnt),
    .host_rvalid  (host_rvalid),
    .host_rdata   (host_rdata),
    .data_req     (data_req),
    .data_we      (data_we),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_gnt     (data_gnt),
    .data_rvalid  (data_rvalid),
    .data_rdata   (data_rdata),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_instr  (fetch_instr),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory, one-cycle read latency, read-before-write.
  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  // req/gnt/rv bit order: {host, data, fetch}
  typedef struct packed {
    logic [2:0]  req;
    logic        hwe;
    logic [15:0] ha;
    logic [31:0] hd;
    logic        dwe;
    logic [15:0] da;
    logic [31:0] dd;
    logic [17:0] fa;
    logic [2:0]  gnt;
    logic [2:0]  rv;
    logic [31:0] rdata;
    logic [7:0]  instr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [2:0] req, input logic hwe, input logic [15:0] ha,
                     input logic [31:0] hd, input logic dwe, input logic [15:0] da,
                     input logic [31:0] dd, input logic [17:0] fa, input logic [2:0] gnt,
                     input logic [2:0] rv, input logic [31:0] rdata, input logic [7:0] instr);
    vec_t v;
    v.req = req; v.hwe = hwe; v.ha = ha; v.hd = hd;
    v.dwe = dwe; v.da = da; v.dd = dd; v.fa = fa;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.instr = instr;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    data_req = 0; data_we = 0; data_addr = '0; data_wdata = '0;
    fetch_req = 0; fetch_addr = '0;
  endtask

  task automatic drive(input vec_t v);
    host_req = v.req[2]; host_we = v.hwe; host_addr = v.ha; host_wdata = v.hd;
    data_req = v.req[1]; data_we = v.dwe; data_addr = v.da; data_wdata = v.dd;
    fetch_req = v.req[0]; fetch_addr = v.fa;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic        e_en, e_we;
    logic [15:0] e_addr;
    logic [31:0] e_wd;
    e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
    if (v.gnt[2]) begin
      e_en = 1; e_we = v.hwe; e_addr = v.ha; e_wd = v.hd;
    end else if (v.gnt[1]) begin
      e_en = 1; e_we = v.dwe; e_addr = v.da; e_wd = v.dd;
    end else if (v.gnt[0]) begin
      e_en = 1; e_addr = v.fa[17:2];
    end
    check("gnt", idx, 32'({host_gnt, data_gnt, fetch_gnt}), 32'(v.gnt));
    check("rvalid", idx, 32'({host_rvalid, data_rvalid, fetch_rvalid}), 32'(v.rv));
    check("mem_en", idx, 32'(mem_en), 32'(e_en));
    check("mem_we", idx, 32'(mem_we), 32'(e_we));
    check("mem_addr", idx, 32'(mem_addr), 32'(e_addr));
    check("mem_wdata", idx, mem_wdata, e_wd);
    if (v.rv[2]) check("host_rdata", idx, host_rdata, v.rdata);
    if (v.rv[1]) check("data_rdata", idx, data_rdata, v.rdata);
    if (v.rv[0]) check("fetch_instr", idx, 32'(fetch_instr), 32'(v.instr));
  endtask

  // One cycle of stimulus: drive just after the rising edge, sample at the falling edge.
  task automatic step(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    check_vec(idx, v);
  endtask

  initial begin
    vec_t v;
    logic [2:0] seq_gnt [0:4];

    // Writes then single data read
    add(3'b100, 1, 16'h0010, 32'hDEADBEEF, 0, 16'h0, 32'h0, 18'h0, 3'b100, 3'b000, 32'h0, 8'h0);
    add(3'b000, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0, 18'h0, 3'b000, 3'b000, 32'h0, 8'h0);
    add(3'b010, 0, 16'h0, 32'h0, 0, 16'h0010, 32'h0BADF00D, 18'h0, 3'b010, 3'b000, 32'h0, 8'h0);
    add(3'b000, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0, 18'h0, 3'b000, 3'b010, 32'hDEADBEEF, 8'h0);
    // Fetch byte select over word 0x0010 = 0x44332211
    add(3'b100, 1, 16'h0010, 32'h44332211, 0, 16'h0, 32'h0, 18'h0, 3'b100, 3'b000, 32'h0, 8'h0);
    add(3'b001, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0, 18'h00042, 3'b001, 3'b000, 32'h0, 8'h00);
    add(3'b001, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0, 18'h00040, 3'b001, 3'b001, 32'h0, 8'h33);
    add(3'b001, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0, 18'h00041, 3'b001, 3'b001, 32'h0, 8'h11);
    add(3'b001, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0, 18'h00043, 3'b001, 3'b001, 32'h0, 8'h22);
    add(3'b000, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0, 18'h0, 3'b000, 3'b001, 32'h0, 8'h44);
    // Host write then data read of the same word next cycle
    add(3'b100, 1, 16'h0020, 32'h12345678, 0, 16'h0, 32'h0, 18'h0, 3'b100, 3'b000, 32'h0, 8'h0);
    add(3'b010, 0, 16'h0, 32'h0, 0, 16'h0020, 32'h0, 18'h0, 3'b010, 3'b000, 32'h0, 8'h0);
    add(3'b000, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0, 18'h0, 3'b000, 3'b010, 32'h12345678, 8'h0);
    // Host priority with all three requesting
    add(3'b111, 0, 16'h0010, 32'h0, 0, 16'h0020, 32'h0, 18'h00042, 3'b100, 3'b000, 32'h0, 8'h0);
    add(3'b011, 0, 16'h0, 32'h0, 0, 16'h0020, 32'h0, 18'h00042, 3'b010, 3'b100, 32'h44332211,
        8'h0);
    add(3'b001, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0, 18'h00042, 3'b001, 3'b010, 32'h12345678, 8'h0);
    add(3'b000, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0, 18'h0, 3'b000, 3'b001, 32'h0, 8'h33);
    // Starvation: data and fetch held continuously, fetch wins every 5th cycle
    for (int i = 0; i < 10; i++) begin
      logic [2:0] g;
      logic [2:0] r;
      g = (i == 4 || i == 9) ? 3'b001 : 3'b010;
      r = (i == 0) ? 3'b000 : (i == 5) ? 3'b001 : 3'b010;
      add(3'b011, 0, 16'h0, 32'h0, 0, 16'h0010, 32'h0, 18'h00041, g, r, 32'h44332211, 8'h22);
    end
    add(3'b000, 0, 16'h0, 32'h0, 0, 16'h0, 32'h0, 18'h0, 3'b000, 3'b001, 32'h0, 8'h22);

    // Reset state
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rvalid", 0, 32'({host_rvalid, data_rvalid, fetch_rvalid}), 32'h0);
    check("reset_gnt", 0, 32'({host_gnt, data_gnt, fetch_gnt}), 32'h0);
    check("reset_instr", 0, 32'(fetch_instr), 32'h00);
    check("reset_mem_en", 0, 32'(mem_en), 32'h0);
    check("reset_mem_addr", 0, 32'(mem_addr), 32'h0);
    check("reset_mem_wdata", 0, mem_wdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vq[i]) step(vq[i], i);

    // Reset mid-read with a partially built starvation count
    for (int i = 0; i < 3; i++) begin
      v = '0;
      v.req = 3'b011; v.da = 16'h0010; v.fa = 18'h00041; v.gnt = 3'b010;
      v.rv = (i == 0) ? 3'b000 : 3'b010; v.rdata = 32'h44332211;
      step(v, 100 + i);
    end
    @(posedge clk);
    #1;
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_data_rvalid", 0, 32'(data_rvalid), 32'h0);
    check("midrst_mem_en", 0, 32'(mem_en), 32'h0);
    check("midrst_wait_cnt", 0, 32'(dut.wait_cnt_q), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_gnt", 0, 32'({host_gnt, data_gnt, fetch_gnt}), 32'h0);
    check("postrst_rvalid", 0, 32'({host_rvalid, data_rvalid, fetch_rvalid}), 32'h0);
    // A cleared counter gives four data grants before fetch wins.
    seq_gnt[0] = 3'b010; seq_gnt[1] = 3'b010; seq_gnt[2] = 3'b010;
    seq_gnt[3] = 3'b010; seq_gnt[4] = 3'b001;
    for (int i = 0; i < 5; i++) begin
      v = '0;
      v.req = 3'b011; v.da = 16'h0010; v.fa = 18'h00041; v.gnt = seq_gnt[i];
      v.rv = (i == 0) ? 3'b000 : 3'b010; v.rdata = 32'h44332211;
      step(v, 200 + i);
    end
    @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
    check("postrst_fetch_rvalid", 0, 32'(fetch_rvalid), 32'h1);
    check("postrst_fetch_instr", 0, 32'(fetch_instr), 32'h22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_mem_arb.md
# hex_mem_arb

Three-port arbiter that shares the single-port hex processor memory between a host/loader port, the processor data port and the processor instruction-fetch port. It sits between the processor core and the synchronous word-wide memory (MEM_DEPTH words × MEM_WIDTH bits, one-cycle read latency). It grants at most one access per cycle and routes read data back to the winning requester. It also extracts the addressed instruction byte for fetches.

## Interface
- FETCH_MAX_WAIT, 4: consecutive denied fetch cycles after which fetch beats data; legal range 1..15.
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- host_req  in  1  host access request; held until host_gnt
- host_we  in  1  1 = write, 0 = read
- host_addr  in  waddr_t (16)  word address
- host_wdata  in  data_t (32)  write data
- host_gnt  out  1  access accepted this cycle
- host_rvalid  out  1  read data valid on host_rdata
- host_rdata  out  data_t  read data
- data_req, data_we, data_addr (waddr_t), data_wdata, data_gnt, data_rvalid, data_rdata: same meanings and widths as the host_* ports, for the core load/store port (LDAM/LDBM/STAM/LDAI/LDBI/STAI).
- fetch_req  in  1  instruction fetch request; read-only
- fetch_addr  in  iaddr_t (18)  byte address
- fetch_gnt  out  1  fetch accepted
- fetch_rvalid  out  1  fetch data valid
- fetch_instr  out  instr_t (8)  addressed instruction byte
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  waddr_t  memory word address
- mem_wdata  out  data_t  memory write data
- mem_rdata  in  data_t  memory read data, valid the cycle after a read with mem_en=1

## Operation
- Arbitration is combinational from the current requests and the registered starvation state. At most one *_gnt is high per cycle.
- Priority order:
  1. host always wins.
  2. If starved=1 and fetch_req=1, fetch beats data.
  3. Otherwise data beats fetch.
- Memory outputs on a grant:
  - mem_en=1.
  - mem_addr = winner's word address. For fetch this is fetch_addr[17:2].
  - mem_we = winner's we. Fetch is always 0.
  - mem_wdata = winner's wdata. Fetch drives 0.
- With no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Starvation counter wait_cnt (4 bits):
  - Increments, saturating at FETCH_MAX_WAIT, when fetch_req=1 and fetch_gnt=0.
  - Clears to 0 when fetch_gnt=1 or fetch_req=0.
  - starved = (wait_cnt == FETCH_MAX_WAIT).
- Read return:
  - A registered 2-bit tag records the read winner: none, host, data or fetch. A write grant records none.
  - The next cycle, exactly the tagged port's rvalid is high.
  - host_rdata and data_rdata are driven from mem_rdata continuously; they are meaningful only while the matching rvalid is high.
- Fetch byte select: a registered copy of fetch_addr[1:0] is captured on fetch_gnt. fetch_instr = mem_rdata byte selected little-endian: 0 → [7:0], 1 → [15:8], 2 → [23:16], 3 → [31:24].
- Requester rule: req, we, addr and wdata stay stable while req=1 and gnt=0. A requester may drop req only after gnt. A requester may issue a new request in the same cycle its rvalid is high.
- Writes produce no rvalid. The grant cycle is the completion.

## Timing
- Grant latency: 0 cycles. A request is granted in its first cycle if it wins.
- Read latency: rvalid exactly 1 cycle after gnt. This sustains one access per cycle back-to-back.
- Write: memory is updated at the clock edge ending the grant cycle. A read of the same address granted in the next cycle returns the new value.
- Reset values: wait_cnt=0, tag=none, byte-select=0. Therefore all *_rvalid=0, fetch_instr=0x00 and the mem_* outputs follow the idle (no-grant) rule.
- Reset asserted mid-operation: any pending rvalid is dropped and is not reissued after reset. Requesters re-request.
- A data and a fetch request in the same cycle with starved=0: data granted. Fetch is granted once starved, if host is idle.
- Continuous host requests block both core ports indefinitely. This is by design; the host is used only while the core is halted.

## Test plan
- Single data read: data_req=1, data_addr=0x0010, mem holds 0xDEADBEEF → data_gnt same cycle, data_rvalid=1 and data_rdata=0xDEADBEEF next cycle; other rvalids 0.
- Fetch byte select: fetch_addr=0x00042, word 0x0010 holds 0x44332211 → mem_addr=0x0010, fetch_rvalid next cycle with fetch_instr=0x33; repeat for offsets 0, 1 and 3 giving 0x11, 0x22 and 0x44.
- Starvation: data_req and fetch_req held continuously with FETCH_MAX_WAIT=4 → data granted 4 cycles, fetch granted in cycle 5, then data, with the pattern repeating.
- Host priority: all three request at once → host_gnt only; host then idle → data, then fetch as above.
- Write then read: host writes 0x12345678 to 0x0020, then data reads 0x0020 the next cycle → data_rdata=0x12345678, and no rvalid for the write.
- Reset mid-read: assert rst in the cycle after data_gnt → data_rvalid=0, mem_en=0, wait_cnt=0; after release, an idle bus produces no grants.
